// File: rtl/xor_checksum_if.sv
// Stream interface for xor_checksum: word input channel and result output channel.
// The slave modport is the checksum engine. The master modport is the word source and result consumer.
interface xor_checksum_if #(
    parameter int WIDTH   = 16,
    parameter int MAX_LEN = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_checksum;
    logic [LEN_W-1:0] out_len;
    logic             out_parity;
    logic             out_overflow;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_checksum, out_len, out_parity, out_overflow
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_checksum, out_len, out_parity, out_overflow
    );
endinterface

// File: rtl/xor_checksum.sv
// Streaming XOR checksum engine.
// Each accepted word is folded into a running accumulator. At frame end the checksum,
// the saturated length, the parity and the overflow flag are registered onto a
// valid/ready result port. A pending result back-pressures the input unless the
// consumer takes the result on the same edge.
module xor_checksum #(
    parameter int WIDTH   = 16,
    parameter int MAX_LEN = 8
) (
    input  logic          clk,
    input  logic          reset,
    xor_checksum_if.slave bus
);
    localparam int               LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MAX_C = LEN_W'(MAX_LEN);

    logic [WIDTH-1:0] acc;
    logic [LEN_W-1:0] cnt;
    logic             ovf;

    logic             accept;
    logic             at_max;
    logic [WIDTH-1:0] fold;
    logic [LEN_W-1:0] cnt_next;

    // Word count saturating at MAX_LEN; the result is always representable in LEN_W bits.
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] c);
        if (c >= MAX_C)
            return MAX_C;
        return c + LEN_W'(1);
    endfunction

    // A stalled result blocks new words unless it is being drained this cycle.
    assign bus.in_ready = ~bus.out_valid | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;
    assign at_max       = (cnt == MAX_C);
    // The first word of a frame replaces the stale accumulator contents.
    assign fold         = (cnt == '0) ? bus.in_data : (acc ^ bus.in_data);
    assign cnt_next     = sat_inc(cnt);

    // Frame accumulator: fold accepted words, and clear when the frame's last word is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            if (bus.in_last) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end else begin
                acc <= fold;
                cnt <= cnt_next;
                ovf <= ovf | at_max;
            end
        end
    end

    // Result register: load on frame end, which also covers the back-to-back case; drop valid once consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid    <= 1'b0;
            bus.out_checksum <= '0;
            bus.out_len      <= '0;
            bus.out_parity   <= 1'b0;
            bus.out_overflow <= 1'b0;
        end else if (accept && bus.in_last) begin
            bus.out_valid    <= 1'b1;
            bus.out_checksum <= fold;
            bus.out_len      <= cnt_next;
            bus.out_parity   <= ^fold;
            bus.out_overflow <= ovf | at_max;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_xor_checksum.sv
// Directed bench for xor_checksum (WIDTH=16, MAX_LEN=8).
// A behavioural model pushes the expected result of each frame into a queue when its last word is accepted.
// Each result handshake pops the queue and compares.
module tb_xor_checksum;
    localparam int WIDTH   = 16;
    localparam int MAX_LEN = 8;

    typedef struct packed {
        logic [15:0] cs;
        logic [3:0]  len;
        logic        par;
        logic        ovf;
    } res_t;

    logic clk;
    logic reset;

    xor_checksum_if #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) bus ();

    xor_checksum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors;
    int          checks;
    int          n_results;
    res_t        sb[$];
    logic [15:0] m_acc;
    int          m_cnt;
    logic        m_ovf;
    logic        acc_flag;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acc = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    // One clock: at the falling edge, score a result handshake, then run the model on an accepted word.
    task automatic tick();
        res_t e;
        acc_flag = 1'b0;
        @(negedge clk);
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                n_results++;
                chk("sb_checksum", {16'h0, bus.out_checksum}, {16'h0, e.cs});
                chk("sb_len",      {28'h0, bus.out_len},      {28'h0, e.len});
                chk("sb_parity",   {31'h0, bus.out_parity},   {31'h0, e.par});
                chk("sb_overflow", {31'h0, bus.out_overflow}, {31'h0, e.ovf});
            end
        end
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
            acc_flag = 1'b1;
            m_acc = (m_cnt == 0) ? bus.in_data : (m_acc ^ bus.in_data);
            if (m_cnt == MAX_LEN) m_ovf = 1'b1;
            if (m_cnt < MAX_LEN) m_cnt++;
            if (bus.in_last === 1'b1) begin
                e.cs  = m_acc;
                e.len = 4'(m_cnt);
                e.par = ^m_acc;
                e.ovf = m_ovf;
                sb.push_back(e);
                model_clear();
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until it is accepted; an expired bound counts as a failure.
    task automatic send(input logic [15:0] d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (acc_flag) break;
        end
        if (!acc_flag) chk("accept_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] cs,
                           input logic [3:0] len, input logic par, input logic ovf);
        chk({tag, "_valid"},    {31'h0, bus.out_valid},    {31'h0, v});
        chk({tag, "_checksum"}, {16'h0, bus.out_checksum}, {16'h0, cs});
        chk({tag, "_len"},      {28'h0, bus.out_len},      {28'h0, len});
        chk({tag, "_parity"},   {31'h0, bus.out_parity},   {31'h0, par});
        chk({tag, "_overflow"}, {31'h0, bus.out_overflow}, {31'h0, ovf});
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        n_results = 0;
        acc_flag  = 1'b0;
        model_clear();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk_out("reset", 1'b0, 16'h0, 4'd0, 1'b0, 1'b0);
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("reset_in_ready", {31'h0, bus.in_ready}, 32'd1);

        // Reset in the middle of a frame discards the partial frame.
        bus.out_ready = 1'b1;
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b0);
        send(16'h4444, 1'b0);
        reset = 1'b1;
        #1;
        model_clear();
        sb.delete();
        chk_out("midreset", 1'b0, 16'h0, 4'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        chk("midreset_in_ready", {31'h0, bus.in_ready}, 32'd1);

        // Three-word frame accumulated from a fresh start.
        send(16'h00FF, 1'b0);
        send(16'h0F0F, 1'b0);
        send(16'hFFFF, 1'b1);
        chk_out("frame3", 1'b1, 16'hF00F, 4'd3, 1'b0, 1'b0);
        tick();
        chk("frame3_drained", {31'h0, bus.out_valid}, 32'd0);

        // Single-word frame, then the consumer stalls for five cycles with a word waiting.
        bus.out_ready = 1'b0;
        send(16'h0001, 1'b1);
        chk_out("single", 1'b1, 16'h0001, 4'd1, 1'b1, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        bus.in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", {31'h0, bus.in_ready}, 32'd0);
            tick();
            chk("stall_accept", {31'h0, acc_flag}, 32'd0);
            chk_out("stall", 1'b1, 16'h0001, 4'd1, 1'b1, 1'b0);
        end
        // Releasing the stall drains the result and takes the waiting word on the same edge.
        bus.out_ready = 1'b1;
        tick();
        chk("release_accept", {31'h0, acc_flag}, 32'd1);
        chk("release_valid", {31'h0, bus.out_valid}, 32'd0);
        send(16'h0F00, 1'b1);
        chk_out("after_stall", 1'b1, 16'h1D34, 4'd2, 1'b1, 1'b0);
        tick();

        // Ten-word frame overflows MAX_LEN; the length saturates and the accumulation continues.
        for (int i = 1; i <= 10; i++) send(16'(i), (i == 10));
        chk_out("overflow", 1'b1, 16'h000B, 4'd8, 1'b1, 1'b1);
        tick();
        chk("overflow_drained", {31'h0, bus.out_valid}, 32'd0);

        // Back-to-back single-word frames keep out_valid high.
        send(16'hAAAA, 1'b1);
        chk_out("b2b_first", 1'b1, 16'hAAAA, 4'd1, 1'b0, 1'b0);
        send(16'h5555, 1'b1);
        chk_out("b2b_second", 1'b1, 16'h5555, 4'd1, 1'b0, 1'b0);
        tick();
        chk("b2b_drained", {31'h0, bus.out_valid}, 32'd0);

        chk("results_seen", 32'(n_results), 32'd6);
        chk("sb_left", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
